key_decoder_n: RTL

KEY_DECODER_N -- requirements
Module: key_decoder_n

---
 rtl/key_decoder_n.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/key_decoder_n.sv
// PS/2 scan-code decoder for a small set of keys: make/break parsing, held levels,
// press pulses and typematic-style auto-repeat on the most recently pressed key.
module key_decoder_n #(
    parameter int unsigned          N_KEYS        = 4,
    parameter logic [N_KEYS*8-1:0]  KEY_CODES     = {8'h74, 8'h6B, 8'h72, 8'h75},
    parameter logic [N_KEYS-1:0]    KEY_EXT       = 4'b1111,
    parameter bit                   STRICT_EXT    = 1'b0,
    parameter int unsigned          REPEAT_DELAY  = 25_000_000,
    parameter int unsigned          REPEAT_PERIOD = 5_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [7:0]        scan_byte,
    output logic [N_KEYS-1:0] key_pulse,
    output logic [N_KEYS-1:0] key_held,
    output logic [3:0]        last_key,
    output logic              any_held
);

    localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW      = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DLY_TERM = CW'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
    localparam logic [CW-1:0] PER_TERM = CW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam bit            REP_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t state_q, state_d;
    logic   make_ev, brk_ev, ev_ext;
    logic   is_e0, is_f0, is_junk;

    assign is_e0   = (scan_byte == 8'hE0);
    assign is_f0   = (scan_byte == 8'hF0);
    assign is_junk = (scan_byte inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF});

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (code_valid) begin
            case (state_q)
                IDLE:         if (is_e0) state_d = EXT;
                              else if (is_f0) state_d = BRK;
                EXT:          if (is_f0) state_d = EXT_BRK;
                              else if (!is_e0) state_d = IDLE;
                BRK, EXT_BRK: state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        ev_ext  = 1'b0;
        if (code_valid) begin
            case (state_q)
                IDLE:    make_ev = !(is_e0 || is_f0 || is_junk);
                EXT: begin
                    make_ev = !(is_e0 || is_f0);
                    ev_ext  = 1'b1;
                end
                BRK:     brk_ev = 1'b1;
                EXT_BRK: begin
                    brk_ev = 1'b1;
                    ev_ext = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [N_KEYS-1:0] held_q, held_d, pulse_q, pulse_d;
    logic [N_KEYS-1:0] match_oh, last_oh;
    logic [3:0]        last_q, last_d, match_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              found, make_acc, brk_acc, rep_fire;

    // Lowest matching index wins, so stop marking once one is found.
    always_comb begin
        match_oh  = '0;
        match_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (!found && scan_byte == KEY_CODES[i*8 +: 8] &&
                (!STRICT_EXT || ev_ext == KEY_EXT[i])) begin
                match_oh[i] = 1'b1;
                match_idx   = 4'(i);
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        last_oh = '0;
        for (int unsigned i = 0; i < N_KEYS; i++)
            last_oh[i] = (last_q == 4'(i));
    end

    assign make_acc = make_ev && found && !(|(held_q & match_oh));
    assign brk_acc  = brk_ev && found;
    assign rep_fire = REP_EN && |(held_q & last_oh) &&
                      (cnt_q == (first_q ? DLY_TERM : PER_TERM)) &&
                      !make_acc && !(brk_acc && |(match_oh & last_oh));

    always_comb begin
        held_d  = held_q;
        pulse_d = '0;
        last_d  = last_q;
        first_d = first_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (make_acc) begin
            held_d  = held_q | match_oh;
            pulse_d = match_oh;
            last_d  = match_idx;
            cnt_d   = '0;
            first_d = 1'b1;
        end else if (rep_fire) begin
            pulse_d = last_oh;
            cnt_d   = '0;
            first_d = 1'b0;
        end
        if (brk_acc) held_d = held_d & ~match_oh;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            held_q  <= '0;
            pulse_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            held_q  <= held_d;
            pulse_q <= pulse_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign key_pulse = pulse_q;
    assign key_held  = held_q;
    assign last_key  = last_q;
    assign any_held  = |held_q;

endmodule
